// File: rtl/fault_injector.sv
// Scripted single-bit fault injector sitting between the ALU replicas and the voter.
// A fault can be stuck-at-0, stuck-at-1 or a bit-flip, and starts after a programmed delay.
module fault_injector #(
  parameter int WIDTH = 32,
  parameter int N     = 7,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           replica,
  input  logic [4:0]           bitpos,
  input  logic [1:0]           mode,
  input  logic [CW-1:0]        delay,
  input  logic [CW-1:0]        duration,
  input  logic [N*WIDTH-1:0]   din,
  output logic [N*WIDTH-1:0]   dout,
  output logic                 busy,
  output logic                 active,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           inj_count
);

  localparam int IW = $clog2(N*WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    INJECT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rep_q, rep_d;
  logic [4:0]    bit_q, bit_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] dur_q, dur_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    inj_count_q, inj_count_d;
  logic          req_ok;
  logic [IW-1:0] fault_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rep_q       <= '0;
      bit_q       <= '0;
      mode_q      <= '0;
      dur_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      inj_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      bit_q       <= bit_d;
      mode_q      <= mode_d;
      dur_q       <= dur_d;
      done_q      <= done_d;
      err_q       <= err_d;
      inj_count_q <= inj_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    bit_d       = bit_q;
    mode_d      = mode_q;
    dur_d       = dur_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    inj_count_d = inj_count_q;

    req_ok = ({29'd0, replica} < 32'(N)) && (mode != 2'b11) &&
             ({27'd0, bitpos} < 32'(WIDTH));

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else begin
            rep_d  = replica;
            bit_d  = bitpos;
            mode_d = mode;
            dur_d  = duration;
            if (delay == '0) begin
              state_d = INJECT;
              cnt_d   = duration;
              if (inj_count_q != 8'hFF) inj_count_d = inj_count_q + 8'd1;
            end else begin
              state_d = DELAY;
              cnt_d   = delay;
            end
          end
        end
      end

      DELAY: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = INJECT;
          cnt_d   = dur_q;
          if (inj_count_q != 8'hFF) inj_count_d = inj_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      INJECT: begin
        // A latched duration of zero means the fault holds until abort or reset.
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (dur_q != '0) begin
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dout      = din;
    fault_idx = IW'(rep_q) * IW'(WIDTH) + IW'(bit_q);
    if (state_q == INJECT) begin
      case (mode_q)
        2'b00:   dout[fault_idx] = 1'b0;
        2'b01:   dout[fault_idx] = 1'b1;
        default: dout[fault_idx] = ~din[fault_idx];
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign active    = (state_q == INJECT);
  assign done      = done_q;
  assign err       = err_q;
  assign inj_count = inj_count_q;

endmodule
